// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: execute-to-writeback stage downstream of the 16-bit ALU.
//
// Captures ALU results with destination info, owns the architectural condition-code (CC)
// register, evaluates branch conditions against it, and buffers register-file writes in a
// 2-entry FIFO with valid/ready handshakes on both sides.
//
// Optional feature (macro WB_BYPASS_EN): when the FIFO is empty and wb_ready_i is high, an
// accepted pushable entry is driven onto wb_* combinationally in the same cycle and is not
// stored. With the macro undefined there is no combinational path from in_* to wb_*.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  upstream handshake (in_ready_o = FIFO not full)
//   in_result_i, in_rd_i   ALU result and destination register
//   in_{s,z,c,v}_i         ALU flags
//   in_wr_en_i             instruction writes in_rd_i
//   in_set_cc_i            instruction updates CC (ignored for branches)
//   in_is_branch_i         conditional branch, condition in in_cond_i
//   wb_valid_o/wb_ready_i  register-file write handshake; wb_data_o/wb_addr_o head entry
//   cc_{s,z,c,v}_o         CC register
//   branch_taken_o         registered one-cycle branch outcome pulse
module alu_writeback_stage #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     in_result_i,
  input  logic                  in_s_i,
  input  logic                  in_z_i,
  input  logic                  in_c_i,
  input  logic                  in_v_i,
  input  logic [REG_ADDR_W-1:0] in_rd_i,
  input  logic                  in_wr_en_i,
  input  logic                  in_set_cc_i,
  input  logic                  in_is_branch_i,
  input  logic [2:0]            in_cond_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [DATA_W-1:0]     wb_data_o,
  output logic [REG_ADDR_W-1:0] wb_addr_o,
  output logic                  cc_s_o,
  output logic                  cc_z_o,
  output logic                  cc_c_o,
  output logic                  cc_v_o,
  output logic                  branch_taken_o
);

  // FIFO storage; contents need no reset because outputs are gated by count.
  logic [DATA_W-1:0]     mem_data_q [2];
  logic [REG_ADDR_W-1:0] mem_addr_q [2];
  logic                  wptr_q, wptr_d;
  logic                  rptr_q, rptr_d;
  logic [1:0]            count_q, count_d;

  logic [3:0]            cc_q, cc_d;        // {s, z, c, v}
  logic                  branch_taken_q, branch_taken_d;

  logic                  accept;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  bypass;

  assign in_ready_o = (count_q != 2'd2);
  assign accept     = in_valid_i & in_ready_o;
  assign push_req   = accept & in_wr_en_i & ~in_is_branch_i;

`ifdef WB_BYPASS_EN
  assign bypass = push_req & wb_ready_i & (count_q == 2'd0);
`else
  assign bypass = 1'b0;
`endif

  assign push = push_req & ~bypass;
  // When empty nothing is presented, so wb_ready_i is ignored.
  assign pop  = (count_q != 2'd0) & wb_ready_i;

  // Writeback outputs: head entry, forced to zero while empty.
  always_comb begin
    wb_valid_o = (count_q != 2'd0);
    wb_data_o  = '0;
    wb_addr_o  = '0;
    if (wb_valid_o) begin
      wb_data_o = mem_data_q[rptr_q];
      wb_addr_o = mem_addr_q[rptr_q];
    end
    if (bypass) begin
      wb_valid_o = 1'b1;
      wb_data_o  = in_result_i;
      wb_addr_o  = in_rd_i;
    end
  end

  // Pointer and occupancy update.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = ~wptr_q;
    if (pop)  rptr_d = ~rptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // CC load and branch evaluation; the branch sees the CC held before this edge.
  always_comb begin
    logic eq;
    logic lt;
    logic taken;
    cc_d  = cc_q;
    eq    = cc_q[2];
    lt    = cc_q[3] ^ cc_q[0];
    taken = 1'b0;
    unique case (in_cond_i)
      3'd0:    taken = eq;
      3'd1:    taken = lt;
      3'd2:    taken = eq | lt;
      3'd3:    taken = ~eq;
      3'd4:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
    branch_taken_d = accept & in_is_branch_i & taken;
    if (accept & in_set_cc_i & ~in_is_branch_i) begin
      cc_d = {in_s_i, in_z_i, in_c_i, in_v_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q         <= 1'b0;
      rptr_q         <= 1'b0;
      count_q        <= 2'd0;
      cc_q           <= 4'd0;
      branch_taken_q <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      cc_q           <= cc_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data_q[wptr_q] <= in_result_i;
      mem_addr_q[wptr_q] <= in_rd_i;
    end
  end

  assign cc_s_o         = cc_q[3];
  assign cc_z_o         = cc_q[2];
  assign cc_c_o         = cc_q[1];
  assign cc_v_o         = cc_q[0];
  assign branch_taken_o = branch_taken_q;

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute-to-writeback stage directly downstream of the 16-bit ALU.
- Captures the ALU result and the S/Z/C/V flags together with destination-register info.
- Owns the architectural condition-code (CC) register and evaluates branch conditions against it.
- Buffers register-file writes in a 2-entry FIFO with valid/ready handshakes on both sides, so regfile back-pressure never corrupts results.

Parameters:
- DATA_W, 16, width of ALU result and writeback data.
- REG_ADDR_W, 3, register-file address width (8 GPRs).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU stage presents an instruction.
- in_ready  out  1  stage can accept; equals (count != 2).
- in_result  in  DATA_W  ALU result.
- in_s, in_z, in_c, in_v  in  1 each  ALU flags.
- in_rd  in  REG_ADDR_W  destination register.
- in_wr_en  in  1  instruction writes in_rd.
- in_set_cc  in  1  instruction updates CC.
- in_is_branch  in  1  conditional branch instruction.
- in_cond  in  3  branch condition code.
- wb_valid  out  1  head FIFO entry valid.
- wb_ready  in  1  register file accepts write.
- wb_data  out  DATA_W  head entry data.
- wb_addr  out  REG_ADDR_W  head entry address.
- cc_s, cc_z, cc_c, cc_v  out  1 each  CC register.
- branch_taken  out  1  registered one-cycle pulse.

Behaviour:
- Accept = in_valid & in_ready. All side effects below occur only on accept.
- Push (FIFO):
  - On accept with in_wr_en=1 and in_is_branch=0, push {in_result, in_rd} into the FIFO.
  - Entries with in_wr_en=0 are consumed (accepted) but not pushed.
- Pop (FIFO):
  - Pop on wb_valid & wb_ready.
  - wb_valid = (count != 0); wb_data/wb_addr show the head entry; order is strictly FIFO.
- Latency: an entry accepted at edge N is visible on wb_* after edge N (1 cycle).
- Count rules:
  - Push only: count+1.
  - Pop only: count-1.
  - Simultaneous push and pop (count 1): count stays 1; the new entry becomes head after the old head leaves.
  - count==2: in_ready=0, so no push regardless of pop in the same cycle; in_ready rises the cycle after a pop.
  - count==0: wb_valid=0; wb_ready is ignored.
- FIFO pointers: 1-bit read/write pointers wrap modulo 2.
- CC register:
  - On accept with in_set_cc=1 and in_is_branch=0, load {in_s,in_z,in_c,in_v} at the edge; otherwise hold.
  - in_set_cc is ignored when in_is_branch=1.
- Branch evaluation:
  - On accept with in_is_branch=1, evaluate in_cond against the CC value held *before* that edge.
  - Register the result into branch_taken for exactly one cycle; it is 0 in all other cycles.
  - cond 0 (BE): taken = cc_z.
  - cond 1 (BLT): taken = cc_s ^ cc_v.
  - cond 2 (BLE): taken = cc_z | (cc_s ^ cc_v).
  - cond 3 (BNE): taken = ~cc_z.
  - cond 4 (BAL): always taken.
  - cond 5-7: never taken.
- Back-to-back ordering: a set_cc instruction accepted at edge N followed by a branch accepted at edge N+1 sees the updated flags.
- Reset (asynchronous, rst_n=0):
  - count=0, pointers=0, wb_valid=0, wb_data=0, wb_addr=0, cc_*=0, branch_taken=0.
  - Storage contents are don't-care but outputs are forced to 0.
  - Reset mid-operation discards all buffered entries immediately; no write is issued after deassertion until a new push.
- Inputs are only sampled on accept; changes while in_ready=0 have no effect.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - When count==0 and wb_ready=1, an accepted pushable entry is driven combinationally onto wb_* in the same cycle (wb_valid=1) and is not stored; zero latency.
  - If wb_ready=0 in that cycle, the entry is stored normally.
  - wb_valid then depends combinationally on in_valid/in_wr_en.
- Not defined: no combinational path from in_* to wb_*; latency fixed at 1 cycle.

Test Plan:
- Reset then single write: in_result=0x1234, in_rd=5, in_wr_en=1, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_addr=5; following cycle wb_valid=0.
- Back-pressure: wb_ready=0, push 0x0001,0x0002,0x0003 on consecutive cycles -> third not accepted (in_ready=0 after two); release wb_ready -> data 0x0001 then 0x0002, then 0x0003 once accepted.
- CC/branch: set_cc with s=1,v=0 then branch cond 1 next cycle -> branch_taken=1 one cycle; then set_cc z=1, branch cond 3 -> branch_taken=0; cond 4 -> 1.
- Branch with in_set_cc=1, in_z=1 while cc_z=0 -> cc_z stays 0; branch not pushed into FIFO (wb_valid stays 0).
- Reset mid-stream: two entries buffered, assert rst_n=0 asynchronously between edges -> wb_valid, cc_*, branch_taken go 0 immediately; after release count=0, in_ready=1.
- WB_BYPASS_EN defined: empty FIFO, wb_ready=1, push 0xBEEF rd=2 -> wb_valid=1, wb_data=0xBEEF same cycle; count remains 0.
